cfntt_addr_gen: RTL
===================

// Module: cfntt_addr_gen
// PURPOSE
//  Read/write address and routing-select generator for the 2-butterfly, 4-bank
//  conflict-free NTT datapath. Sequences all LOGN in-place Cooley-Tukey stages.
//  Per cycle: bank read addresses, twiddle indices and sel_a_0..3 for the input
//  network, plus write-back addresses/selects delayed to match the datapath.
//  Sits upstream of the bank RAMs and the input network, which registers sel_a.
// PARAMETERS
//  LOGN    8  log2 of transform size N (N=2^LOGN, >=4); bank depth N/4
//  WB_LAT  8  cycles from rd_en to matching wr_en (RAM + network + butterfly); >=1
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-low reset
//  start      in   1       begin a full transform; sampled only in IDLE
//  busy       out  1       high from cycle after start accepted until done pulse
//  done       out  1       one-cycle pulse after last write-back
//  rd_en      out  1       bank read strobe (all 4 banks)
//  rd_addr_m  out  LOGN-2  read address of bank m, m=0..3
//  sel_a_m    out  2       port fed by bank m: 00=u0 01=v0 10=u1 11=v1
//  tw_idx_0/1 out  LOGN    twiddle ROM index for butterfly 0/1
//  wr_en      out  1       bank write strobe
//  wr_addr_m  out  LOGN-2  write address of bank m
//  sel_w_m    out  2       butterfly output port written into bank m (same coding)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0, delay line cleared; async assert
//   at any time (incl. mid-transform) aborts; no done is produced.
//  FSM: IDLE -start-> RUN; RUN -(k==N/4-1)-> GAP; GAP -(g==WB_LAT-1)->
//   RUN with s+1 if s<LOGN-1, else DONE; DONE -> IDLE (done=1 for that cycle).
//  start while busy is ignored. Accepted start at edge e -> first rd_en at e+1.
//  Counters: stage s 0..LOGN-1, cycle k 0..N/4-1, gap g 0..WB_LAT-1; all clear
//   on leaving their state; no wrap beyond terminal values.
//  Index math (RUN, registered outputs): t=LOGN-1-s, d=2^t; butterfly
//   b0=k, b1=k+N/4; j=insert 0 at bit t of b (j=((b>>t)<<(t+1))|(b&(d-1)));
//   u0=j0, v0=j0+d, u1=j1, v1=j1+d.
//  Bank map: bank(i)={i[LOGN-1], ^i}; addr(i)=i[LOGN-2:1]. Four indices always
//   hit four distinct banks; sel_a_m = port whose index maps to bank m.
//  Twiddle: tw_idx_x = (1<<s) + (j_x >> (t+1)), LOGN bits, no overflow.
//  rd_addr/sel_a change only with rd_en=1; hold last value when rd_en=0.
//  Write-back: WB_LAT-deep shift register of {rd_en, rd_addr_0..3, sel_a_0..3}
//   -> {wr_en, wr_addr_0..3, sel_w_0..3}; in-place, same addresses.
//  GAP of WB_LAT cycles guarantees stage s writes finish before stage s+1 reads.
//  Latency: first rd_en at e+1; done at e+1+LOGN*(N/4+WB_LAT).
// STRUCTURE
//  Package cfntt_pkg: LOGN default, port codes U0/V0/U1/V1, FSM state enum,
//   bank/addr functions shared with the network and RAM wrappers.
//  Sub-module cfntt_bank_map: index -> {bank, addr}; 4 instances, combinational.
//  Delay line inline (generic shift register), FSM + counters in top.
// TESTING (LOGN=8, WB_LAT=8)
//  Reset mid-RUN (s=3,k=20) -> all outputs 0 async, IDLE; next start runs s=0,k=0.
//  s=0,k=0 -> rd_addr_0..3=0,32,32,0; sel_a_0..3=00,10,11,01; tw_idx_0/1=1,1.
//  s=7,k=0 -> rd_addr_0..3=0,0,0,0; sel_a_0..3=00,01,11,10; tw_idx_0/1=128,192.
//  Full run: rd_en high 64 cycles x8 with 8-cycle gaps; done at e+577; busy
//   drops with done; start pulsed while busy has no effect.
//  Every cycle: 4 banks distinct; wr_* equals rd_* delayed exactly 8 cycles.
//  Scoreboard: each index 0..255 read once and written once per stage.

Source files
------------

// File: rtl/cfntt_pkg.sv
// Shared definitions for the conflict-free NTT datapath: default sizes,
// butterfly port codes and the address-generator FSM states.
package cfntt_pkg;

    localparam int LOGN_DEF   = 8;
    localparam int WB_LAT_DEF = 8;

    typedef enum logic [1:0] {
        PORT_U0 = 2'b00,
        PORT_V0 = 2'b01,
        PORT_U1 = 2'b10,
        PORT_V1 = 2'b11
    } port_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/cfntt_addr_gen_if.sv
// Control/address bundle between the NTT address generator and the
// bank RAMs plus input/output routing networks.
interface cfntt_addr_gen_if
    import cfntt_pkg::*;
#(
    parameter int LOGN = LOGN_DEF
);

    logic            start;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [LOGN-3:0] rd_addr [4];
    logic [1:0]      sel_a   [4];
    logic [LOGN-1:0] tw_idx_0;
    logic [LOGN-1:0] tw_idx_1;
    logic            wr_en;
    logic [LOGN-3:0] wr_addr [4];
    logic [1:0]      sel_w   [4];

    modport master (
        input  start,
        output busy, done, rd_en, rd_addr, sel_a, tw_idx_0, tw_idx_1,
               wr_en, wr_addr, sel_w
    );

    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr, sel_a, tw_idx_0, tw_idx_1,
               wr_en, wr_addr, sel_w
    );

endinterface

// File: rtl/cfntt_bank_map.sv
// Coefficient index -> {bank, row}. Top bit plus parity spreads every
// butterfly pair of a stage across all four banks.
module cfntt_bank_map
    import cfntt_pkg::*;
#(
    parameter int LOGN = LOGN_DEF
) (
    input  logic [LOGN-1:0] i_idx,
    output logic [1:0]      o_bank,
    output logic [LOGN-3:0] o_addr
);

    assign o_bank = {i_idx[LOGN-1], ^i_idx};
    assign o_addr = i_idx[LOGN-2:1];

endmodule

// File: rtl/cfntt_addr_gen.sv
// Stage/cycle sequencer for the 2-butterfly, 4-bank in-place NTT: read
// addresses, twiddle indices and routing selects, plus delayed write-back.
module cfntt_addr_gen
    import cfntt_pkg::*;
#(
    parameter int LOGN   = LOGN_DEF,
    parameter int WB_LAT = WB_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    cfntt_addr_gen_if.master bus
);

    localparam int AW = LOGN - 2;
    localparam int SW = $clog2(LOGN);
    localparam int GW = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;
    localparam int DW = 1 + 4 * AW + 8;

    state_e          r_state;
    state_e          w_nextState;
    logic [SW-1:0]   r_stage;
    logic [AW-1:0]   r_cycle;
    logic [GW-1:0]   r_gap;
    logic            w_lastCycle;
    logic            w_lastGap;
    logic            w_lastStage;

    logic            w_rdEnNext;
    logic            w_busyNext;
    logic            w_doneNext;

    logic [SW-1:0]   w_shift;
    logic [LOGN-1:0] w_d;
    logic [LOGN-1:0] w_mask;
    logic [LOGN-1:0] w_b0;
    logic [LOGN-1:0] w_b1;
    logic [LOGN-1:0] w_j0;
    logic [LOGN-1:0] w_j1;
    logic [LOGN-1:0] w_tw0;
    logic [LOGN-1:0] w_tw1;
    logic [LOGN-1:0] w_portIdx  [4];
    logic [1:0]      w_portBank [4];
    logic [AW-1:0]   w_portAddr [4];
    logic [AW-1:0]   w_bankAddr [4];
    port_e           w_bankSel  [4];

    logic            r_rdEn;
    logic            r_busy;
    logic            r_done;
    logic [AW-1:0]   r_rdAddr [4];
    logic [1:0]      r_selA   [4];
    logic [LOGN-1:0] r_tw0;
    logic [LOGN-1:0] r_tw1;

    logic [DW-1:0]   r_dly [WB_LAT];
    logic [DW-1:0]   w_dlyIn;
    logic [DW-1:0]   w_dlyOut;

    assign w_lastCycle = &r_cycle;
    assign w_lastGap   = (r_gap == GW'(WB_LAT - 1));
    assign w_lastStage = (r_stage == SW'(LOGN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (bus.start)  w_nextState = ST_RUN;
            ST_RUN:  if (w_lastCycle) w_nextState = ST_GAP;
            ST_GAP:  if (w_lastGap)   w_nextState = w_lastStage ? ST_DONE : ST_RUN;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdEnNext = (r_state == ST_RUN);
        w_busyNext = (r_state == ST_RUN) || (r_state == ST_GAP);
        w_doneNext = (r_state == ST_DONE);
    end

    // Counters fall back to zero whenever their state is left, so an aborted
    // or finished transform always restarts from stage 0, cycle 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
            r_cycle <= '0;
            r_gap   <= '0;
        end else begin
            r_cycle <= (r_state == ST_RUN && !w_lastCycle) ? r_cycle + 1'b1 : '0;
            r_gap   <= (r_state == ST_GAP && !w_lastGap) ? r_gap + 1'b1 : '0;
            if (r_state == ST_GAP && w_lastGap) begin
                r_stage <= w_lastStage ? '0 : r_stage + 1'b1;
            end
        end
    end

    // Butterfly index j is the butterfly number with a zero inserted at bit t;
    // its partner sits at distance d = 2^t.
    always_comb begin
        w_shift = SW'(LOGN - 1) - r_stage;
        w_d     = LOGN'(1) << w_shift;
        w_mask  = w_d - LOGN'(1);
        w_b0    = {2'b00, r_cycle};
        w_b1    = {2'b01, r_cycle};
        w_j0    = ((w_b0 & ~w_mask) << 1) | (w_b0 & w_mask);
        w_j1    = ((w_b1 & ~w_mask) << 1) | (w_b1 & w_mask);
        w_portIdx[0] = w_j0;
        w_portIdx[1] = w_j0 | w_d;
        w_portIdx[2] = w_j1;
        w_portIdx[3] = w_j1 | w_d;
        w_tw0 = (LOGN'(1) << r_stage) + ((w_j0 >> w_shift) >> 1);
        w_tw1 = (LOGN'(1) << r_stage) + ((w_j1 >> w_shift) >> 1);
    end

    for (genvar p = 0; p < 4; p++) begin : g_map
        cfntt_bank_map #(.LOGN(LOGN)) u_map (
            .i_idx  (w_portIdx[p]),
            .o_bank (w_portBank[p]),
            .o_addr (w_portAddr[p])
        );
    end

    always_comb begin
        for (int m = 0; m < 4; m++) begin
            w_bankAddr[m] = '0;
            w_bankSel[m]  = PORT_U0;
        end
        for (int p = 0; p < 4; p++) begin
            w_bankAddr[w_portBank[p]] = w_portAddr[p];
            w_bankSel[w_portBank[p]]  = port_e'(p[1:0]);
        end
    end

    // Read-side outputs only move on a read cycle and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdEn <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_tw0  <= '0;
            r_tw1  <= '0;
            for (int m = 0; m < 4; m++) begin
                r_rdAddr[m] <= '0;
                r_selA[m]   <= '0;
            end
        end else begin
            r_rdEn <= w_rdEnNext;
            r_busy <= w_busyNext;
            r_done <= w_doneNext;
            if (w_rdEnNext) begin
                r_tw0 <= w_tw0;
                r_tw1 <= w_tw1;
                for (int m = 0; m < 4; m++) begin
                    r_rdAddr[m] <= w_bankAddr[m];
                    r_selA[m]   <= w_bankSel[m];
                end
            end
        end
    end

    assign w_dlyIn = {r_rdEn, r_rdAddr[3], r_rdAddr[2], r_rdAddr[1], r_rdAddr[0],
                      r_selA[3], r_selA[2], r_selA[1], r_selA[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WB_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= w_dlyIn;
            for (int i = 1; i < WB_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_dlyOut = r_dly[WB_LAT-1];

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_en    = r_rdEn;
    assign bus.tw_idx_0 = r_tw0;
    assign bus.tw_idx_1 = r_tw1;
    assign bus.wr_en    = w_dlyOut[DW-1];

    for (genvar m = 0; m < 4; m++) begin : g_out
        assign bus.rd_addr[m] = r_rdAddr[m];
        assign bus.sel_a[m]   = r_selA[m];
        assign bus.wr_addr[m] = w_dlyOut[8 + m*AW +: AW];
        assign bus.sel_w[m]   = w_dlyOut[2*m +: 2];
    end

endmodule
